// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the PBL processor core.
//
// Holds the current instruction address. Each enabled cycle it picks the next
// address from the decoded control-flow class: NEXT, JUMP, CALL, RET or HALT.
// It drives the return-address stack's call/ret/clear strobes and the
// called_from address. On a return it takes return_to from that stack.
//
// Optional feature macro: PC_STACK_GUARD_EN
//   defined   : a depth counter tracks live stack entries. A CALL on a full
//               stack, or a RET on an empty stack, enters a sticky FAULT state.
//   undefined : there is no depth counter. depth and fault are tied to 0, and
//               CALL/RET always strobe the stack.
//
// Ports:
//   clock        in   core clock, rising edge
//   reset        in   asynchronous active-low reset
//   enable       in   instruction valid; op is acted on only when high
//   op[2:0]      in   0 NEXT, 1 JUMP, 2 CALL, 3 RET, 4 HALT, 5-7 as NEXT
//   target       in   destination for JUMP/CALL
//   return_to    in   top-of-stack return address (combinational from stack)
//   resume       in   leave HALT
//   pc           out  current instruction address
//   called_from  out  equals pc; the stack stores called_from+1
//   stack_call   out  call strobe to the stack
//   stack_ret    out  return strobe to the stack
//   stack_clr    out  synchronous clear to the stack
//   depth        out  live stack entries
//   halted       out  sequencer is in HALT (registered)
//   fault        out  sticky stack fault (registered)
module pc_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [2:0]                     op,
  input  logic [PC_WIDTH-1:0]            target,
  input  logic [PC_WIDTH-1:0]            return_to,
  input  logic                           resume,
  output logic [PC_WIDTH-1:0]            pc,
  output logic [PC_WIDTH-1:0]            called_from,
  output logic                           stack_call,
  output logic                           stack_ret,
  output logic                           stack_clr,
  output logic [$clog2(STACK_DEPTH):0]   depth,
  output logic                           halted,
  output logic                           fault
);

  localparam int DW = $clog2(STACK_DEPTH) + 1;

  localparam logic [2:0] OP_JUMP = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_HALT = 3'd4;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [PC_WIDTH-1:0] pc_n;
  logic                halted_q;

`ifdef PC_STACK_GUARD_EN
  localparam logic [DW-1:0] DEPTH_FULL = DW'(STACK_DEPTH);
  logic [DW-1:0] depth_q, depth_n;
  logic          fault_q;
`endif

  // Next-state and strobe logic. The strobes are combinational, so the stack
  // updates on the same edge as pc.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    stack_call = 1'b0;
    stack_ret  = 1'b0;
    stack_clr  = 1'b0;
`ifdef PC_STACK_GUARD_EN
    depth_n    = depth_q;
`endif
    case (state)
      S_INIT: begin
        stack_clr = 1'b1;
        state_n   = S_RUN;
      end
      S_RUN: begin
        if (enable) begin
          case (op)
            OP_JUMP: pc_n = target;
            OP_CALL: begin
`ifdef PC_STACK_GUARD_EN
              // A full stack faults instead of overwriting its oldest entry.
              if (depth_q == DEPTH_FULL) begin
                state_n = S_FAULT;
              end else begin
                stack_call = 1'b1;
                pc_n       = target;
                depth_n    = depth_q + DW'(1);
              end
`else
              stack_call = 1'b1;
              pc_n       = target;
`endif
            end
            OP_RET: begin
`ifdef PC_STACK_GUARD_EN
              if (depth_q == '0) begin
                state_n = S_FAULT;
              end else begin
                stack_ret = 1'b1;
                pc_n      = return_to;
                depth_n   = depth_q - DW'(1);
              end
`else
              stack_ret = 1'b1;
              pc_n      = return_to;
`endif
            end
            OP_HALT: state_n = S_HALT;
            default: pc_n = pc + PC_WIDTH'(1);
          endcase
        end
      end
      S_HALT: begin
        if (resume) begin
          state_n = S_RUN;
          pc_n    = pc + PC_WIDTH'(1);
        end
      end
      default: ;  // FAULT: everything holds until reset
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_INIT;
      pc       <= '0;
      halted_q <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      halted_q <= (state_n == S_HALT);
    end
  end

`ifdef PC_STACK_GUARD_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      depth_q <= '0;
      fault_q <= 1'b0;
    end else begin
      depth_q <= depth_n;
      fault_q <= (state_n == S_FAULT);
    end
  end

  assign depth = depth_q;
  assign fault = fault_q;
`else
  assign depth = '0;
  assign fault = 1'b0;
`endif

  assign halted      = halted_q;
  assign called_from = pc;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the PBL processor core. Holds the current instruction address and selects the next one from the decoded control-flow class: sequential, jump, call, return or halt. It sits directly upstream of the return-address `stack`. It drives that stack's `call`, `ret`, `reset` and `called_from` inputs, and consumes its `return_to` output on returns. Optional depth tracking converts stack overflow and underflow into a sticky fault instead of silent wrap-around.

## Interface
- `PC_WIDTH`, default 8: width of instruction addresses; must match the stack's `PC_WIDTH`.
- `STACK_DEPTH`, default 16: number of return-stack entries; must match the stack.

- `clock`  in  1  single core clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `enable`  in  1  instruction valid / not stalled; `op` is acted on only when high.
- `op`  in  3  control-flow class: 0 NEXT, 1 JUMP, 2 CALL, 3 RET, 4 HALT; codes 5–7 behave as NEXT.
- `target`  in  PC_WIDTH  destination for JUMP/CALL.
- `return_to`  in  PC_WIDTH  top-of-stack return address from the stack (combinational).
- `resume`  in  1  leave HALT.
- `pc`  out  PC_WIDTH  current instruction address.
- `called_from`  out  PC_WIDTH  equals `pc`; stack stores `called_from+1`.
- `stack_call`  out  1  call strobe to stack.
- `stack_ret`  out  1  return strobe to stack.
- `stack_clr`  out  1  synchronous clear to stack.
- `depth`  out  $clog2(STACK_DEPTH)+1  live stack entries.
- `halted`  out  1  sequencer in HALT.
- `fault`  out  1  sticky stack fault.

## Operation
- FSM states: INIT, RUN, HALT, FAULT.
- While `reset`=0: state INIT, `pc`=0, `depth`=0, `halted`=0, `fault`=0, `stack_call`=0, `stack_ret`=0, `stack_clr`=1.
- INIT: `stack_clr`=1; on the next edge go to RUN; `pc` stays 0.
- RUN, `enable`=0: everything holds; no strobes.
- RUN, `enable`=1:
  - NEXT: `pc`<=`pc`+1, modulo 2^PC_WIDTH (0xFF→0x00 at width 8).
  - JUMP: `pc`<=`target`.
  - CALL: `stack_call`=1, `pc`<=`target`, `depth`+1.
  - RET: `stack_ret`=1, `pc`<=`return_to`, `depth`−1.
  - HALT: go to HALT; `pc` holds at the HALT instruction.
- HALT: `halted`=1; `op` and `enable` are ignored; no strobes. `resume`=1 → RUN with `pc`<=`pc`+1.
- FAULT: `fault`=1; `pc` and `depth` hold; no strobes. Leaves only via `reset`.
- `stack_call` and `stack_ret` are mutually exclusive and never asserted outside RUN.

## Timing
- `stack_call`, `stack_ret` and `called_from` are combinational from `state`, `enable`, `op`, `pc` and `depth`. They are valid in the cycle the instruction is presented, so the stack updates on the same edge as `pc`.
- RET samples `return_to` combinationally in the same cycle; `pc` updates on that edge.
- Every instruction takes 1 cycle.
- `halted` and `fault` are registered and assert the cycle after the causing edge.
- `resume` is ignored outside HALT.
- Reset assertion mid-CALL or mid-RET aborts immediately: no partial `depth` or `pc` update is kept.

## Configuration
- `PC_STACK_GUARD_EN` defined:
  - CALL with `depth`==STACK_DEPTH → FAULT; no `stack_call`; `pc` holds.
  - RET with `depth`==0 → FAULT; no `stack_ret`; `pc` holds.
- `PC_STACK_GUARD_EN` undefined:
  - No depth counter and no FAULT state.
  - `depth` and `fault` are tied to 0.
  - CALL/RET always strobe the stack, so the stack's offset wraps silently.

## Test plan
- Release reset: `stack_clr`=1 for exactly one cycle, then three NEXT ops → `pc`=3; with `pc`=0xFF, NEXT → `pc`=0x00.
- At `pc`=0x05, CALL with `target`=0x40 → same cycle `stack_call`=1 and `called_from`=0x05; next `pc`=0x40 and `depth`=1. A following RET with `return_to`=0x06 from the stack model → `stack_ret`=1, `pc`=0x06, `depth`=0.
- With guard, issue 16 nested CALLs → `depth`=16. The 17th CALL → `stack_call`=0, `pc` held, `fault`=1 next cycle. Later ops are ignored until `reset`=0.
- With guard, RET at `depth`=0 → `stack_ret`=0, `fault`=1. Without guard, the same RET gives `stack_ret`=1, `pc`=`return_to` and `fault`=0.
- HALT at `pc`=0x10 → `halted`=1, `pc`=0x10. JUMP with `enable`=1 is ignored. `resume` pulse → `pc`=0x11, `halted`=0.
- Assert `reset` during a CALL cycle → `pc`=0, `depth`=0, and `stack_call` drops immediately.
